// File: rtl/seq_chk_pkg.sv
// Shared limits, per-lane state type and arithmetic helpers for the seq_chk_multi checker.
package seq_chk_pkg;

    localparam int unsigned RMAX_LIM = 8;
    localparam int unsigned FREP_LIM = 8;

    // run[0] holds last cycle's E0; run[k] means E0 then k consecutive E1 samples.
    // pend[k] is a live fulfil thread that must see its stage-k event this cycle.
    typedef struct packed {
        logic [RMAX_LIM:0] run;
        logic [FREP_LIM:0] pend;
    } lane_state_t;

    function automatic logic [3:0] popcount(input logic [FREP_LIM:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i <= FREP_LIM; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/seq_chk_lane.sv
// One checker lane: enabling-sequence tracking, fulfil threads, pass/fail pulses and counters.
// SEQ_CHK_FIRST_FAIL_EN adds first-fail capture of the shared cycle counter.
module seq_chk_lane
    import seq_chk_pkg::*;
#(
    parameter int unsigned RMIN    = 1,
    parameter int unsigned RMAX    = 1,
    parameter int unsigned FREP    = 1,
    parameter int unsigned OVERLAP = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_e0,
    input  logic             ev_e1,
    input  logic             ev_e2,
    input  logic             ev_f0,
    input  logic             ev_f1,
    input  logic             abort,
    input  logic             clr_cnt,
`ifdef SEQ_CHK_FIRST_FAIL_EN
    input  logic [31:0]      cyc,
    output logic             first_fail_vld,
    output logic [31:0]      first_fail_cyc,
`endif
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int unsigned RW = RMAX_LIM + 1;
    localparam int unsigned PW = FREP_LIM + 1;
    localparam logic [RW-1:0] RUN_KEEP = RW'((32'd1 << (RMAX + 1)) - 32'd1);
    localparam logic [RW-1:0] RUN_HIT  =
        RW'(((32'd1 << (RMAX + 1)) - 32'd1) & ~((32'd1 << RMIN) - 32'd1));
    localparam logic [PW-1:0] F0_MASK  = PW'((32'd1 << FREP) - 32'd1);
    localparam logic [PW-1:0] F1_MASK  = PW'(32'd1 << FREP);

    lane_state_t      st_q, st_d;
    logic             match, hit;
    logic [PW-1:0]    cur, adv, dead;
    logic [3:0]       nfail;
    logic             pass_q, fail_q;
    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q, pass_nxt, fail_nxt;

    always_comb begin
        match = ev_e2 && (|(st_q.run & RUN_HIT));
        cur   = st_q.pend;
        if ((OVERLAP != 0) && match) begin
            cur[0] = 1'b1;
        end
        adv  = cur & F0_MASK & {PW{ev_f0}};
        dead = (cur & F0_MASK & ~{PW{ev_f0}}) | (cur & F1_MASK & ~{PW{ev_f1}});
        hit  = (|(cur & F1_MASK)) && ev_f1;
        st_d.run  = (({st_q.run[RW-2:0], 1'b0} & {RW{ev_e1}}) | {{(RW-1){1'b0}}, ev_e0})
                    & RUN_KEEP;
        st_d.pend = ({adv[PW-2:0], 1'b0} | {{(PW-1){1'b0}}, (OVERLAP == 0) && match})
                    & (F0_MASK | F1_MASK);
        // Abort discards this cycle's decisions and everything it would have started.
        if (abort) begin
            st_d = '0;
            hit  = 1'b0;
            dead = '0;
        end
        nfail    = popcount(dead);
        pass_nxt = CNT_W'(sat_add(32'(pass_cnt_q), {31'd0, hit}, CNT_W));
        fail_nxt = CNT_W'(sat_add(32'(fail_cnt_q), {28'd0, nfail}, CNT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            st_q   <= st_d;
            pass_q <= hit;
            fail_q <= |dead;
            if (clr_cnt) begin
                pass_cnt_q <= '0;
                fail_cnt_q <= '0;
            end else begin
                pass_cnt_q <= pass_nxt;
                fail_cnt_q <= fail_nxt;
            end
        end
    end

`ifdef SEQ_CHK_FIRST_FAIL_EN
    logic        ff_vld_q;
    logic [31:0] ff_cyc_q;

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            ff_vld_q <= 1'b0;
            ff_cyc_q <= '0;
        end else if (fail_q && !ff_vld_q) begin
            ff_vld_q <= 1'b1;
            ff_cyc_q <= cyc;
        end
    end

    assign first_fail_vld = ff_vld_q;
    assign first_fail_cyc = ff_cyc_q;
`endif

    assign pass     = pass_q;
    assign fail     = fail_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/seq_chk_multi.sv
// Multi-lane temporal sequence checker: CH independent seq_chk_lane instances.
// SEQ_CHK_FIRST_FAIL_EN adds a free-running cycle counter and per-lane first-fail capture.
module seq_chk_multi
    import seq_chk_pkg::*;
#(
    parameter int unsigned CH      = 2,
    parameter int unsigned RMIN    = 1,
    parameter int unsigned RMAX    = 1,
    parameter int unsigned FREP    = 1,
    parameter int unsigned OVERLAP = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CH-1:0]       ev_e0,
    input  logic [CH-1:0]       ev_e1,
    input  logic [CH-1:0]       ev_e2,
    input  logic [CH-1:0]       ev_f0,
    input  logic [CH-1:0]       ev_f1,
    input  logic [CH-1:0]       abort,
    input  logic                clr_cnt,
`ifdef SEQ_CHK_FIRST_FAIL_EN
    output logic [CH-1:0]       first_fail_vld,
    output logic [CH*32-1:0]    first_fail_cyc,
`endif
    output logic [CH-1:0]       pass,
    output logic [CH-1:0]       fail,
    output logic [CH*CNT_W-1:0] pass_cnt,
    output logic [CH*CNT_W-1:0] fail_cnt
);

`ifdef SEQ_CHK_FIRST_FAIL_EN
    logic [31:0] cyc_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
        end
    end
`endif

    for (genvar i = 0; i < CH; i++) begin : g_lane
        seq_chk_lane #(
            .RMIN    (RMIN),
            .RMAX    (RMAX),
            .FREP    (FREP),
            .OVERLAP (OVERLAP),
            .CNT_W   (CNT_W)
        ) u_lane (
            .clk            (CLK),
            .rst            (RST),
            .ev_e0          (ev_e0[i]),
            .ev_e1          (ev_e1[i]),
            .ev_e2          (ev_e2[i]),
            .ev_f0          (ev_f0[i]),
            .ev_f1          (ev_f1[i]),
            .abort          (abort[i]),
            .clr_cnt        (clr_cnt),
`ifdef SEQ_CHK_FIRST_FAIL_EN
            .cyc            (cyc_q),
            .first_fail_vld (first_fail_vld[i]),
            .first_fail_cyc (first_fail_cyc[i*32 +: 32]),
`endif
            .pass           (pass[i]),
            .fail           (fail[i]),
            .pass_cnt       (pass_cnt[i*CNT_W +: CNT_W]),
            .fail_cnt       (fail_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
